// File: rtl/glyph_item_encoder_if.sv
// Purpose: bundles the glyph input stream, result output stream, abort and counter of glyph_item_encoder.
// Latency: none, signal bundle only.
// Backpressure: glyph_valid/glyph_ready on input, result_valid/result_ready on output.
// Ports: slave = encoder side, master = producer/consumer side.
interface glyph_item_encoder_if #(
   parameter int CNT_W = 8
);
   logic             clear;
   logic [6:0]       glyph_in;
   logic             glyph_valid;
   logic             glyph_ready;
   logic [2:0]       item_code;
   logic             item_err;
   logic             result_valid;
   logic             result_ready;
   logic [CNT_W-1:0] items_count;

   modport slave (
      input  clear, glyph_in, glyph_valid, result_ready,
      output glyph_ready, item_code, item_err, result_valid, items_count
   );

   modport master (
      output clear, glyph_in, glyph_valid, result_ready,
      input  glyph_ready, item_code, item_err, result_valid, items_count
   );
endinterface

// File: rtl/glyph_item_encoder.sv
// Purpose: matches six serial active-low 7-segment glyphs (HEX5 first) against the item table and recovers the item code.
// Latency: result_valid rises the cycle after the 6th glyph is accepted.
// Backpressure: glyph_ready low while a result is pending; the result is held until result_ready.
// Ports: clk, reset_n (async active-low), bus (slave modport: clear, glyph stream, result stream, items_count).
module glyph_item_encoder #(
   parameter int GLYPHS = 6,
   parameter int CNT_W  = 8
) (
   input  logic                 clk,
   input  logic                 reset_n,
   glyph_item_encoder_if.slave  bus
);

   localparam logic [2:0] LAST_POS = 3'(GLYPHS - 1);

   typedef enum logic {COLLECT, RESULT} state_t;

   state_t           state_q, state_d;
   logic [2:0]       pos_q, pos_d;
   logic [5:0]       cand_q, cand_d;
   logic [2:0]       code_q, code_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [5:0]       match;
   logic [5:0]       survivors;

   // Candidate slot k stands for one table item; slot -> code mapping.
   function automatic logic [2:0] slot_code(input int k);
      case (k)
         0:       slot_code = 3'b000;
         1:       slot_code = 3'b100;
         2:       slot_code = 3'b110;
         3:       slot_code = 3'b001;
         4:       slot_code = 3'b101;
         default: slot_code = 3'b011;
      endcase
   endfunction

   // Expected glyph of slot k at position p (position 0 = HEX5).
   function automatic logic [6:0] ref_glyph(input int k, input logic [2:0] p);
      logic [6:0] g;
      g = 7'b1111111;
      case (k)
         0: case (p)
               3'd0: g = 7'b1001110;
               3'd1: g = 7'b1001111;
               3'd2: g = 7'b1001000;
               3'd3: g = 7'b0010000;
               default: g = 7'b1111111;
            endcase
         1: case (p)
               3'd0: g = 7'b0000000;
               3'd1: g = 7'b0001000;
               3'd2: g = 7'b1000111;
               3'd3: g = 7'b1000111;
               default: g = 7'b1111111;
            endcase
         2: case (p)
               3'd0: g = 7'b0000000;
               3'd1: g = 7'b1000000;
               3'd2: g = 7'b1000000;
               3'd3: g = 7'b0000000;
               default: g = 7'b1111111;
            endcase
         3: case (p)
               3'd0: g = 7'b1000000;
               3'd1: g = 7'b0111111;
               3'd2: g = 7'b1000000;
               3'd3: g = 7'b0111011;
               3'd4: g = 7'b0111011;
               default: g = 7'b1111111;
            endcase
         4: case (p)
               3'd0: g = 7'b0001100;
               3'd1: g = 7'b1000110;
               default: g = 7'b1111111;
            endcase
         default: case (p)
               3'd0: g = 7'b1000110;
               3'd1: g = 7'b0001001;
               3'd2: g = 7'b0001000;
               3'd3: g = 7'b1001111;
               3'd4: g = 7'b1001110;
               default: g = 7'b1111111;
            endcase
      endcase
      ref_glyph = g;
   endfunction

   // {err, code}: entries are distinct so at most one survivor exists.
   function automatic logic [3:0] encode(input logic [5:0] c);
      logic [3:0] r;
      r = 4'b1111;
      for (int k = 0; k < 6; k++) begin
         if (c[k]) r = {1'b0, slot_code(k)};
      end
      encode = r;
   endfunction

   always_comb begin
      match = '0;
      for (int k = 0; k < 6; k++) begin
         match[k] = (ref_glyph(k, pos_q) == bus.glyph_in);
      end
   end

   assign survivors = cand_q & match;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= COLLECT;
         pos_q   <= '0;
         cand_q  <= '1;
         code_q  <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pos_q   <= pos_d;
         cand_q  <= cand_d;
         code_q  <= code_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pos_d   = pos_q;
      cand_d  = cand_q;
      code_d  = code_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      if (bus.clear) begin
         // Abort wins over any glyph or result handshake in the same cycle.
         state_d = COLLECT;
         pos_d   = '0;
         cand_d  = '1;
      end else begin
         case (state_q)
            COLLECT: begin
               if (bus.glyph_valid) begin
                  cand_d = survivors;
                  if (pos_q == LAST_POS) begin
                     state_d         = RESULT;
                     pos_d           = '0;
                     {err_d, code_d} = encode(survivors);
                  end else begin
                     pos_d = pos_q + 3'd1;
                  end
               end
            end
            default: begin
               if (bus.result_ready) begin
                  state_d = COLLECT;
                  pos_d   = '0;
                  cand_d  = '1;
                  if (!err_q && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
               end
            end
         endcase
      end
   end

   assign bus.glyph_ready  = (state_q == COLLECT);
   assign bus.result_valid = (state_q == RESULT);
   assign bus.item_code    = code_q;
   assign bus.item_err     = err_q;
   assign bus.items_count  = cnt_q;

endmodule

// File: tb/tb_glyph_item_encoder.sv
`timescale 1ns/1ps
module tb_glyph_item_encoder;

   logic clk;
   logic reset_n;
   int   n_vec;
   int   n_fail;
   int   exp_cnt;

   glyph_item_encoder_if #(.CNT_W(8)) bus ();

   glyph_item_encoder #(.GLYPHS(6), .CNT_W(8)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef logic [5:0][6:0] word_t;   // [5] = HEX5, sent first

   typedef struct {
      word_t      g;
      logic [2:0] code;
      logic       err;
   } vec_t;

   localparam word_t W_RING  = {7'b1001110, 7'b1001111, 7'b1001000, 7'b0010000, 7'b1111111, 7'b1111111};
   localparam word_t W_100   = {7'b0000000, 7'b0001000, 7'b1000111, 7'b1000111, 7'b1111111, 7'b1111111};
   localparam word_t W_110   = {7'b0000000, 7'b1000000, 7'b1000000, 7'b0000000, 7'b1111111, 7'b1111111};
   localparam word_t W_BALL  = {7'b1000000, 7'b0111111, 7'b1000000, 7'b0111011, 7'b0111011, 7'b1111111};
   localparam word_t W_101   = {7'b0001100, 7'b1000110, 7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111};
   localparam word_t W_CHAIR = {7'b1000110, 7'b0001001, 7'b0001000, 7'b1001111, 7'b1001110, 7'b1111111};

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Drives glyphs at negedges; returns at the negedge after the 6th glyph's edge.
   task automatic send_word(input word_t w, input int gap);
      for (int i = 5; i >= 0; i--) begin
         bus.glyph_in    = w[i];
         bus.glyph_valid = 1'b1;
         @(negedge clk);
         bus.glyph_valid = 1'b0;
         if (i != 0) repeat (gap) @(negedge clk);
      end
   endtask

   task automatic bump_model();
      if (exp_cnt != 255) exp_cnt++;
   endtask

   vec_t vecs [8];

   initial begin
      n_vec   = 0;
      n_fail  = 0;
      exp_cnt = 0;

      vecs[0] = '{W_101,   3'b101, 1'b0};
      vecs[1] = '{W_RING,  3'b000, 1'b0};
      vecs[2] = '{W_100,   3'b100, 1'b0};
      vecs[3] = '{W_110,   3'b110, 1'b0};
      vecs[4] = '{W_BALL,  3'b001, 1'b0};
      vecs[5] = '{W_CHAIR, 3'b011, 1'b0};
      // Ring word with last glyph corrupted.
      vecs[6] = '{{7'b1001110, 7'b1001111, 7'b1001000, 7'b0010000, 7'b1111111, 7'b1111110}, 3'b111, 1'b1};
      // Starts like item 100, continues like item 110: no survivor.
      vecs[7] = '{{7'b0000000, 7'b0001000, 7'b1000000, 7'b0000000, 7'b1111111, 7'b1111111}, 3'b111, 1'b1};

      bus.clear        = 1'b0;
      bus.glyph_in     = 7'b1111111;
      bus.glyph_valid  = 1'b0;
      bus.result_ready = 1'b0;
      reset_n          = 1'b0;
      repeat (2) @(negedge clk);

      chk("reset glyph_ready",  int'(bus.glyph_ready), 1);
      chk("reset result_valid", int'(bus.result_valid), 0);
      chk("reset item_code",    int'(bus.item_code), 0);
      chk("reset item_err",     int'(bus.item_err), 0);
      chk("reset items_count",  int'(bus.items_count), 0);
      reset_n = 1'b1;
      @(negedge clk);

      // Table: back-to-back glyphs, consumer always ready -> one-cycle result pulse.
      bus.result_ready = 1'b1;
      for (int v = 0; v < 8; v++) begin
         send_word(vecs[v].g, 0);
         chk($sformatf("v%0d result_valid", v), int'(bus.result_valid), 1);
         chk($sformatf("v%0d glyph_ready", v),  int'(bus.glyph_ready), 0);
         chk($sformatf("v%0d item_code", v),    int'(bus.item_code), int'(vecs[v].code));
         chk($sformatf("v%0d item_err", v),     int'(bus.item_err), int'(vecs[v].err));
         if (!vecs[v].err) bump_model();
         @(negedge clk);
         chk($sformatf("v%0d pulse end", v),    int'(bus.result_valid), 0);
         chk($sformatf("v%0d items_count", v),  int'(bus.items_count), exp_cnt);
      end

      // Chair word with gaps, consumer stalls 5 cycles; stray glyphs must be ignored.
      bus.result_ready = 1'b0;
      send_word(W_CHAIR, 2);
      for (int c = 0; c < 5; c++) begin
         bus.glyph_in    = 7'b0000000;
         bus.glyph_valid = 1'b1;
         chk($sformatf("stall%0d result_valid", c), int'(bus.result_valid), 1);
         chk($sformatf("stall%0d glyph_ready", c),  int'(bus.glyph_ready), 0);
         chk($sformatf("stall%0d item_code", c),    int'(bus.item_code), 3);
         chk($sformatf("stall%0d items_count", c),  int'(bus.items_count), exp_cnt);
         @(negedge clk);
      end
      bus.glyph_valid  = 1'b0;
      bus.result_ready = 1'b1;
      bump_model();
      @(negedge clk);
      chk("stall release count", int'(bus.items_count), exp_cnt);
      chk("stall release ready", int'(bus.glyph_ready), 1);

      // Partial ball word, clear, then ring word.
      for (int i = 5; i >= 3; i--) begin
         bus.glyph_in    = W_BALL[i];
         bus.glyph_valid = 1'b1;
         @(negedge clk);
      end
      bus.glyph_valid = 1'b0;
      bus.clear       = 1'b1;
      @(negedge clk);
      bus.clear = 1'b0;
      send_word(W_RING, 0);
      chk("clear then ring valid", int'(bus.result_valid), 1);
      chk("clear then ring code",  int'(bus.item_code), 0);
      chk("clear then ring err",   int'(bus.item_err), 0);
      bump_model();
      @(negedge clk);
      chk("clear then ring count", int'(bus.items_count), exp_cnt);

      // Clear coinciding with a result handshake: result dropped, not counted.
      send_word(W_101, 0);
      bus.clear = 1'b1;
      @(negedge clk);
      bus.clear = 1'b0;
      chk("clear on handshake valid", int'(bus.result_valid), 0);
      chk("clear on handshake count", int'(bus.items_count), exp_cnt);

      // Saturation: fill to 255, then one more.
      while (exp_cnt < 255) begin
         send_word(W_100, 0);
         bump_model();
         @(negedge clk);
      end
      chk("preload count", int'(bus.items_count), 255);
      send_word(W_110, 0);
      chk("sat result code", int'(bus.item_code), 6);
      @(negedge clk);
      chk("saturated count", int'(bus.items_count), 255);

      // Async reset while a result is pending.
      bus.result_ready = 1'b0;
      send_word(W_BALL, 0);
      chk("pre-reset valid", int'(bus.result_valid), 1);
      #1 reset_n = 1'b0;
      #0.5;
      chk("async reset valid", int'(bus.result_valid), 0);
      chk("async reset count", int'(bus.items_count), 0);
      chk("async reset ready", int'(bus.glyph_ready), 1);
      chk("async reset code",  int'(bus.item_code), 0);
      #0.5 reset_n = 1'b1;
      exp_cnt = 0;
      @(negedge clk);

      // Recovery after reset.
      bus.result_ready = 1'b1;
      send_word(W_CHAIR, 1);
      chk("post-reset code", int'(bus.item_code), 3);
      bump_model();
      @(negedge clk);
      chk("post-reset count", int'(bus.items_count), exp_cnt);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

endmodule

// File: doc/glyph_item_encoder.md
Name: glyph_item_encoder

Overview:
- Reverse of the store item display path: takes a serial stream of six active-low 7-segment glyphs and recovers the 3-bit item code that would have produced them.
- Glyphs arrive in HEX5, HEX4, ..., HEX0 order.
- Used by the checkout side to turn a captured display word back into an item code for downstream stolen/discount logic.
- Also keeps a saturating count of successfully decoded items.

Parameters:
- GLYPHS, 6, glyphs per display word (fixed at 6; other values unsupported).
- CNT_W, 8, width of the decoded-item counter.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous abort; discards a partial word and any pending result.
- glyph_in  input  7  active-low segment pattern, bit 6 = segment g ... bit 0 = segment a.
- glyph_valid  input  1  glyph_in is valid this cycle.
- glyph_ready  output  1  block can accept a glyph this cycle.
- item_code  output  3  decoded item code; 3'b111 when the word did not match.
- item_err  output  1  word did not match any item.
- result_valid  output  1  item_code/item_err are valid.
- result_ready  input  1  consumer accepts the result.
- items_count  output  CNT_W  number of error-free results accepted, saturating.

Behaviour:
- Reset (reset_n low, asynchronous): state COLLECT, position 0, all six candidate bits set.
  - Reset values: glyph_ready=1, result_valid=0, item_code=3'b000, item_err=0, items_count=0.
- Item table, HEX5..HEX0:
  - 000: 1001110 1001111 1001000 0010000 1111111 1111111
  - 100: 0000000 0001000 1000111 1000111 1111111 1111111
  - 110: 0000000 1000000 1000000 0000000 1111111 1111111
  - 001: 1000000 0111111 1000000 0111011 0111011 1111111
  - 101: 0001100 1000110 1111111 1111111 1111111 1111111
  - 011: 1000110 0001001 0001000 1001111 1001110 1111111
  - Codes 010 and 111 have no entry and are never produced as matches.
- A glyph is accepted when glyph_valid and glyph_ready are both high at a rising edge.
- COLLECT state:
  - glyph_ready=1.
  - On each accepted glyph, clear every candidate bit whose table entry at the current position differs from glyph_in.
  - Increment position.
  - On the 6th accepted glyph (position 5), go to RESULT.
- RESULT state:
  - Entered on the clock edge that accepts the 6th glyph; result_valid is high in the following cycle (1-cycle latency).
  - glyph_ready=0; glyphs are not accepted.
  - Exactly one surviving candidate: item_code = that code, item_err=0.
  - Zero survivors: item_code=3'b111, item_err=1.
  - Table entries are distinct, so more than one survivor cannot occur.
  - item_code and item_err are held stable while result_valid=1 and result_ready=0.
  - When result_valid and result_ready are both high at an edge:
    - Return to COLLECT, position 0, all candidates set.
    - If item_err=0, items_count increments, saturating at 2^CNT_W-1 with no wrap.
  - The next glyph can be accepted in the cycle after the handshake, not the same cycle.
- clear:
  - Highest priority after reset.
  - At an edge: go to COLLECT, position 0, all candidates set, result_valid=0.
  - items_count is unchanged.
  - A glyph or result handshake in the same cycle is discarded and not counted.
- reset_n asserted mid-word or mid-result: immediate return to reset values; the partial word is lost.
- Glyphs with glyph_valid low are ignored, and gaps between glyphs are allowed.
- An X or 7'bX glyph_in while glyph_valid is high is illegal stimulus.

Test Plan:
- Reset, then stream 0001100,1000110,1111111,1111111,1111111,1111111 back-to-back with result_ready=1 -> result_valid pulses one cycle after the 6th glyph, item_code=101, item_err=0, items_count=1.
- Stream the chair word (item 011) with 2-cycle gaps and result_ready held 0 for 5 cycles -> glyph_ready=0 and item_code=011 held stable for all 5 cycles; count increments only on the handshake.
- Stream 1001110,1001111,1001000,0010000,1111111,1111110 (last glyph corrupted) -> item_err=1, item_code=111, items_count unchanged.
- Send 3 glyphs of the ball word, pulse clear, then send the full ring word -> item_code=000, item_err=0; the partial word leaves no effect.
- Preload by decoding 255 valid words, then one more -> items_count stays 255.
- Drop reset_n for 1 ns while result_valid=1 -> result_valid=0, items_count=0, glyph_ready=1 immediately, without waiting for a clock edge.
